// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way write-back L1 data cache: access sizes,
// controller states, default geometry and the access legality check.
package dcache_pkg;

   localparam int DEF_WAYS       = 4;
   localparam int DEF_SETS       = 128;
   localparam int DEF_LINE_BYTES = 64;
   localparam int DEF_ADDR_W     = 32;

   localparam int OFF_W = $clog2(DEF_LINE_BYTES);
   localparam int IDX_W = $clog2(DEF_SETS);
   localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      REFILL_REQ,
      REFILL_WAIT,
      RESP
   } cache_state_t;

   // An access is rejected when the size code is illegal or the address is
   // not naturally aligned for the requested size.
   function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the data cache: tag, valid, dirty and line storage for every set.
// Reads are combinational on the set index; writes land on the rising edge.
module dcache_way #(
   parameter int SETS      = 128,
   parameter int IDX_BITS  = 7,
   parameter int TAG_BITS  = 19,
   parameter int LINE_BITS = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_BITS-1:0]  idx,
   input  logic [TAG_BITS-1:0]  cmp_tag,
   input  logic                 wr_en,
   input  logic [TAG_BITS-1:0]  wr_tag,
   input  logic [LINE_BITS-1:0] wr_line,
   input  logic                 wr_dirty,
   output logic                 hit,
   output logic                 valid,
   output logic                 dirty,
   output logic [TAG_BITS-1:0]  tag,
   output logic [LINE_BITS-1:0] line
);

   logic [TAG_BITS-1:0]  tag_mem  [SETS];
   logic [LINE_BITS-1:0] data_mem [SETS];
   logic [SETS-1:0]      valid_bits;
   logic [SETS-1:0]      dirty_bits;

   // State bits are cleared on reset; any write makes the set valid and
   // records whether the line now differs from memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (wr_en) begin
         valid_bits[idx] <= 1'b1;
         dirty_bits[idx] <= wr_dirty;
      end
   end

   // Tag and data storage carry no reset; the valid bit guards their use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[idx]  <= wr_tag;
         data_mem[idx] <= wr_line;
      end
   end

   assign valid = valid_bits[idx];
   assign dirty = dirty_bits[idx];
   assign tag   = tag_mem[idx];
   assign line  = data_mem[idx];
   assign hit   = valid_bits[idx] && (tag_mem[idx] == cmp_tag);

endmodule

// File: rtl/dcache_nway_wb.sv
// N-way set-associative, write-back, write-allocate blocking L1 data cache.
// One request is handled at a time; misses go through a writeback/refill
// sequence on a line-wide memory handshake, with round-robin replacement.
// Optional build macro DCACHE_PERF_CNT_EN adds saturating hit/miss/writeback
// counters on ports perf_hits, perf_misses and perf_wbs.
module dcache_nway_wb
   import dcache_pkg::*;
#(
   parameter int WAYS       = DEF_WAYS,
   parameter int SETS       = DEF_SETS,
   parameter int LINE_BYTES = DEF_LINE_BYTES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int TAG_ID_W   = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [31:0]             req_wdata,
   input  logic [TAG_ID_W-1:0]     req_id,
   output logic                    resp_valid,
   output logic [31:0]             resp_data,
   output logic [TAG_ID_W-1:0]     resp_id,
   output logic                    resp_err,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_write,
   output logic [ADDR_W-1:0]       mem_req_addr,
   output logic [LINE_BYTES*8-1:0] mem_req_wdata,
   input  logic                    mem_resp_valid,
   input  logic [LINE_BYTES*8-1:0] mem_resp_data
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]             perf_hits,
   output logic [31:0]             perf_misses,
   output logic [31:0]             perf_wbs
`endif
);

   localparam int OFF_BITS  = $clog2(LINE_BYTES);
   localparam int IDX_BITS  = $clog2(SETS);
   localparam int TAG_BITS  = ADDR_W - IDX_BITS - OFF_BITS;
   localparam int LINE_BITS = LINE_BYTES * 8;
   localparam int WAY_W     = $clog2(WAYS);

   cache_state_t state;

   logic                r_write;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [TAG_ID_W-1:0] r_id;
   logic [WAY_W-1:0]    vic_q;

   logic [TAG_BITS-1:0] r_tag;
   logic [IDX_BITS-1:0] r_idx;
   logic [OFF_BITS-1:0] r_off;

   logic [WAYS-1:0]      hit_vec;
   logic [WAYS-1:0]      way_valid;
   logic [WAYS-1:0]      way_dirty;
   logic [TAG_BITS-1:0]  way_tag  [WAYS];
   logic [LINE_BITS-1:0] way_line [WAYS];
   logic [WAYS-1:0]      way_we;
   logic [LINE_BITS-1:0] wr_line;
   logic                 wr_dirty;

   logic                 any_hit;
   logic [LINE_BITS-1:0] hit_line;
   logic                 vic_found;
   logic [WAY_W-1:0]     vic_way;
   logic                 vic_needs_wb;
   logic [TAG_BITS-1:0]  vic_tag;
   logic [LINE_BITS-1:0] vic_line;

   logic [WAY_W-1:0] rr_ptr [SETS];

   assign r_tag = r_addr[ADDR_W-1 -: TAG_BITS];
   assign r_idx = r_addr[OFF_BITS +: IDX_BITS];
   assign r_off = r_addr[OFF_BITS-1:0];

   // Pull an aligned byte/half/word out of a line and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [LINE_BITS-1:0] ln,
                                                input logic [OFF_BITS-1:0]  off,
                                                input logic [1:0]           size,
                                                input logic                 sgn);
      logic [LINE_BITS+31:0] padded;
      logic [31:0]           raw;
      logic [31:0]           res;
      padded = {32'b0, ln};
      raw    = padded[{off, 3'b000} +: 32];
      case (size)
         SZ_BYTE: res = {{24{sgn & raw[7]}}, raw[7:0]};
         SZ_HALF: res = {{16{sgn & raw[15]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   // Overlay the enabled bytes of right-aligned store data onto a line.
   function automatic logic [LINE_BITS-1:0] store_merge(input logic [LINE_BITS-1:0] ln,
                                                        input logic [OFF_BITS-1:0]  off,
                                                        input logic [1:0]           size,
                                                        input logic [31:0]          wdata);
      logic [31:0]          lane_mask;
      logic [LINE_BITS-1:0] m;
      logic [LINE_BITS-1:0] d;
      case (size)
         SZ_BYTE: lane_mask = 32'h0000_00FF;
         SZ_HALF: lane_mask = 32'h0000_FFFF;
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
      m = LINE_BITS'(lane_mask) << {off, 3'b000};
      d = LINE_BITS'(wdata) << {off, 3'b000};
      return (ln & ~m) | (d & m);
   endfunction

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      dcache_way #(
         .SETS      (SETS),
         .IDX_BITS  (IDX_BITS),
         .TAG_BITS  (TAG_BITS),
         .LINE_BITS (LINE_BITS)
      ) u_way (
         .clk      (clk),
         .rst      (rst),
         .idx      (r_idx),
         .cmp_tag  (r_tag),
         .wr_en    (way_we[g]),
         .wr_tag   (r_tag),
         .wr_line  (wr_line),
         .wr_dirty (wr_dirty),
         .hit      (hit_vec[g]),
         .valid    (way_valid[g]),
         .dirty    (way_dirty[g]),
         .tag      (way_tag[g]),
         .line     (way_line[g])
      );
   end

   // Select the line of whichever way matched; at most one bit is set.
   always_comb begin
      any_hit  = |hit_vec;
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_vec[w]) begin
            hit_line = hit_line | way_line[w];
         end
      end
   end

   // Victim is the lowest-numbered empty way, else the set's round-robin way.
   always_comb begin
      vic_found = 1'b0;
      vic_way   = rr_ptr[r_idx];
      for (int w = 0; w < WAYS; w++) begin
         if (!vic_found && !way_valid[w]) begin
            vic_way   = WAY_W'(w);
            vic_found = 1'b1;
         end
      end
   end

   assign vic_needs_wb = way_valid[vic_way] && way_dirty[vic_way];
   assign vic_tag      = way_tag[vic_way];
   assign vic_line     = way_line[vic_way];

   // Array writes: store hits merge into the matching way; refills install
   // the memory line in the victim way, merging store data on the way in.
   always_comb begin
      way_we   = '0;
      wr_line  = '0;
      wr_dirty = 1'b0;
      if (!rst) begin
         if (state == LOOKUP && any_hit && r_write) begin
            way_we   = hit_vec;
            wr_line  = store_merge(hit_line, r_off, r_size, r_wdata);
            wr_dirty = 1'b1;
         end else if (state == REFILL_WAIT && mem_resp_valid) begin
            way_we[vic_q] = 1'b1;
            wr_line       = r_write ? store_merge(mem_resp_data, r_off, r_size, r_wdata)
                                    : mem_resp_data;
            wr_dirty      = r_write;
         end
      end
   end

   // Round-robin pointers advance only when a refill installs a line.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            rr_ptr[s] <= '0;
         end
      end else if (state == REFILL_WAIT && mem_resp_valid) begin
         rr_ptr[r_idx] <= rr_ptr[r_idx] + 1'b1;
      end
   end

   // Request sequencing with registered handshake and response outputs; the
   // response pulse is raised on the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_id       <= '0;
         resp_err      <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         r_write       <= 1'b0;
         r_size        <= SZ_BYTE;
         r_signed      <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_id          <= '0;
         vic_q         <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         resp_id    <= '0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  r_write   <= req_write;
                  r_size    <= req_size;
                  r_signed  <= req_signed;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  r_id      <= req_id;
                  req_ready <= 1'b0;
                  if (is_bad_access(req_size, req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_id    <= req_id;
                  end else begin
                     state <= LOOKUP;
                  end
               end
            end
            LOOKUP: begin
               if (any_hit) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_id    <= r_id;
                  resp_data  <= r_write ? 32'h0
                                        : load_extract(hit_line, r_off, r_size, r_signed);
               end else begin
                  vic_q         <= vic_way;
                  mem_req_valid <= 1'b1;
                  if (vic_needs_wb) begin
                     state         <= WB;
                     mem_req_write <= 1'b1;
                     mem_req_addr  <= {vic_tag, r_idx, {OFF_BITS{1'b0}}};
                     mem_req_wdata <= vic_line;
                  end else begin
                     state         <= REFILL_REQ;
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= {r_tag, r_idx, {OFF_BITS{1'b0}}};
                  end
               end
            end
            WB: begin
               if (mem_req_ready) begin
                  state         <= REFILL_REQ;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b0;
                  mem_req_addr  <= {r_tag, r_idx, {OFF_BITS{1'b0}}};
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready) begin
                  state         <= REFILL_WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            REFILL_WAIT: begin
               if (mem_resp_valid) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_id    <= r_id;
                  resp_data  <= r_write ? 32'h0
                                        : load_extract(mem_resp_data, r_off, r_size, r_signed);
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   // A lookup must never see the same tag resident in two ways of one set.
   assert property (@(posedge clk) disable iff (rst) (state == LOOKUP) |-> $onehot0(hit_vec));

`ifdef DCACHE_PERF_CNT_EN
   // Saturating event counters for hits, misses and completed writebacks.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_hits   <= '0;
         perf_misses <= '0;
         perf_wbs    <= '0;
      end else begin
         if (state == LOOKUP && any_hit && perf_hits != '1) begin
            perf_hits <= perf_hits + 32'd1;
         end
         if (state == LOOKUP && !any_hit && perf_misses != '1) begin
            perf_misses <= perf_misses + 32'd1;
         end
         if (state == WB && mem_req_ready && perf_wbs != '1) begin
            perf_wbs <= perf_wbs + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_nway_wb.sv
// Directed self-checking bench for dcache_nway_wb: cold miss refill, store/load
// hits with extension, set overflow with dirty writeback, alignment errors,
// memory back-pressure and reset mid-miss, plus optional perf counters.
module tb_dcache_nway_wb;
   import dcache_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [1:0]   req_size;
   logic         req_signed;
   logic [31:0]  req_addr;
   logic [31:0]  req_wdata;
   logic [5:0]   req_id;
   logic         resp_valid;
   logic [31:0]  resp_data;
   logic [5:0]   resp_id;
   logic         resp_err;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic         mem_req_write;
   logic [31:0]  mem_req_addr;
   logic [511:0] mem_req_wdata;
   logic         mem_resp_valid;
   logic [511:0] mem_resp_data;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  perf_hits;
   logic [31:0]  perf_misses;
   logic [31:0]  perf_wbs;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int exp_hits = 0;
   int exp_misses = 0;
   int exp_wbs  = 0;

   dcache_nway_wb #(
      .WAYS       (4),
      .SETS       (128),
      .LINE_BYTES (64),
      .ADDR_W     (32),
      .TAG_ID_W   (6)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_id         (req_id),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .resp_id        (resp_id),
      .resp_err       (resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_write  (mem_req_write),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .perf_hits      (perf_hits),
      .perf_misses    (perf_misses),
      .perf_wbs       (perf_wbs)
`endif
   );

   always #5 clk = ~clk;

   // Step one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value with its expectation and record the outcome.
   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Present one request for a single accepting edge.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [5:0] id);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_id     = id;
      tick();
      req_valid  = 1'b0;
   endtask

   // Act as backing memory for one line transfer, checking the request.
   task automatic serveMem(input string tag, input logic exp_write, input logic [31:0] exp_addr,
                           input logic [511:0] exp_wline, input logic [511:0] rline);
      int n = 0;
      while (!mem_req_valid && n < 40) begin
         tick();
         n++;
      end
      if (!mem_req_valid) begin
         checkOutput({tag, "_req_timeout"}, 1'b0, 1'b1);
         return;
      end
      checkOutput({tag, "_wr"}, mem_req_write, exp_write);
      checkOutput({tag, "_addr"}, mem_req_addr, exp_addr);
      if (exp_write) checkOutput({tag, "_wdata"}, mem_req_wdata, exp_wline);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      if (!exp_write) begin
         mem_resp_data  = rline;
         mem_resp_valid = 1'b1;
         tick();
         mem_resp_valid = 1'b0;
      end
   endtask

   // Wait (bounded) for the response pulse, check it, then return to idle.
   task automatic waitResp(input string tag, input logic [31:0] exp_data,
                           input logic [5:0] exp_id, input logic exp_err);
      int n = 0;
      while (!resp_valid && n < 40) begin
         tick();
         n++;
      end
      if (!resp_valid) begin
         checkOutput({tag, "_resp_timeout"}, 1'b0, 1'b1);
         return;
      end
      checkOutput({tag, "_data"}, resp_data, exp_data);
      checkOutput({tag, "_id"}, resp_id, exp_id);
      checkOutput({tag, "_err"}, resp_err, exp_err);
      tick();
   endtask

   // A hit answers exactly two cycles after acceptance without memory traffic.
   task automatic hitResp(input string tag, input logic [31:0] exp_data, input logic [5:0] exp_id);
      checkOutput({tag, "_t1"}, resp_valid, 1'b0);
      tick();
      checkOutput({tag, "_t2"}, resp_valid, 1'b1);
      checkOutput({tag, "_nomem"}, mem_req_valid, 1'b0);
      waitResp(tag, exp_data, exp_id, 1'b0);
   endtask

   function automatic logic [31:0] mkAddr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
      return {t, i, {OFF_W{1'b0}}};
   endfunction

   function automatic logic [511:0] mkLine(input logic [31:0] w0);
      logic [511:0] l;
      l = '0;
      l[31:0] = w0;
      return l;
   endfunction

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic stable;
      int   n;
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; req_id = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      repeat (3) tick();
      checkOutput("rst_req_ready", req_ready, 1'b1);
      checkOutput("rst_resp_valid", resp_valid, 1'b0);
      checkOutput("rst_mem_valid", mem_req_valid, 1'b0);
      checkOutput("rst_mem_addr", mem_req_addr, 32'h0);
      rst = 1'b0;
      tick();

      // cold word load: miss and refill
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h0000_1040, 32'h0, 6'd5);
      checkOutput("s1_busy", req_ready, 1'b0);
      serveMem("s1_refill", 1'b0, 32'h0000_1040, '0, mkLine(32'hDEAD_BEEF));
      waitResp("s1", 32'hDEAD_BEEF, 6'd5, 1'b0);
      exp_misses++;

      // store byte hit then loads of the merged line
      applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h0000_1041, 32'h0000_0080, 6'd6);
      hitResp("s2_st", 32'h0, 6'd6);
      exp_hits++;
      mem_resp_data  = '1;
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("stray_mem_resp", resp_valid, 1'b0);
      applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h0000_1041, 32'h0, 6'd7);
      hitResp("s2_ldb", 32'hFFFF_FF80, 6'd7);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h0000_1040, 32'h0, 6'd8);
      hitResp("s2_ldw", 32'hDEAD_80EF, 6'd8);
      applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h0000_1042, 32'h0, 6'd9);
      hitResp("s2_ldh", 32'hFFFF_DEAD, 6'd9);
      exp_hits += 3;

      // five tags into set 1; the first is dirty and gets written back
      applyStimulus(1'b1, SZ_BYTE, 1'b0, mkAddr(19'd0, 7'd1) | 32'h3, 32'h0000_005A, 6'd10);
      serveMem("s3_a0", 1'b0, mkAddr(19'd0, 7'd1), '0, mkLine(32'h1122_3344));
      waitResp("s3_a0", 32'h0, 6'd10, 1'b0);
      exp_misses++;
      for (int t = 1; t < 4; t++) begin
         applyStimulus(1'b0, SZ_WORD, 1'b0, mkAddr(19'(t), 7'd1), 32'h0, 6'(10 + t));
         serveMem("s3_fill", 1'b0, mkAddr(19'(t), 7'd1), '0, mkLine(32'hA1A1_0000 + 32'(t)));
         waitResp("s3_fill", 32'hA1A1_0000 + 32'(t), 6'(10 + t), 1'b0);
         exp_misses++;
      end
      applyStimulus(1'b0, SZ_WORD, 1'b0, mkAddr(19'd4, 7'd1), 32'h0, 6'd14);
      serveMem("s3_wb", 1'b1, mkAddr(19'd0, 7'd1), mkLine(32'h5A22_3344), '0);
      serveMem("s3_refill4", 1'b0, mkAddr(19'd4, 7'd1), '0, mkLine(32'hA4A4_0004));
      waitResp("s3_a4", 32'hA4A4_0004, 6'd14, 1'b0);
      exp_misses++;
      exp_wbs++;
      applyStimulus(1'b0, SZ_WORD, 1'b0, mkAddr(19'd1, 7'd1), 32'h0, 6'd15);
      hitResp("s3_a1_hit", 32'hA1A1_0001, 6'd15);
      exp_hits++;
      applyStimulus(1'b0, SZ_WORD, 1'b0, mkAddr(19'd0, 7'd1), 32'h0, 6'd16);
      serveMem("s3_a0_back", 1'b0, mkAddr(19'd0, 7'd1), '0, mkLine(32'h5A22_3344));
      waitResp("s3_a0_back", 32'h5A22_3344, 6'd16, 1'b0);
      exp_misses++;

      // alignment and size errors answer at once without memory traffic
      applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h0000_1043, 32'h0, 6'd20);
      checkOutput("s4_half_lat", resp_valid, 1'b1);
      checkOutput("s4_half_nomem", mem_req_valid, 1'b0);
      waitResp("s4_half", 32'h0, 6'd20, 1'b1);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_1040, 32'h0, 6'd21);
      waitResp("s4_size", 32'h0, 6'd21, 1'b1);
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h0000_1042, 32'hFFFF_FFFF, 6'd22);
      waitResp("s4_word", 32'h0, 6'd22, 1'b1);
      checkOutput("s4_nomem", mem_req_valid, 1'b0);

`ifdef DCACHE_PERF_CNT_EN
      checkOutput("perf_hits", perf_hits, 32'(exp_hits));
      checkOutput("perf_misses", perf_misses, 32'(exp_misses));
      checkOutput("perf_wbs", perf_wbs, 32'(exp_wbs));
`endif

      // back-pressure on the refill request, then reset mid-miss
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h0000_3000, 32'h0, 6'd30);
      n = 0;
      while (!mem_req_valid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("s5_req", mem_req_valid, 1'b1);
      checkOutput("s5_addr", mem_req_addr, 32'h0000_3000);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!mem_req_valid || mem_req_addr !== 32'h0000_3000 || mem_req_write !== 1'b0 ||
             req_ready !== 1'b0) stable = 1'b0;
      end
      checkOutput("s5_stable", stable, 1'b1);
      rst = 1'b1;
      tick();
      checkOutput("s5_rst_memvalid", mem_req_valid, 1'b0);
      checkOutput("s5_rst_ready", req_ready, 1'b1);
      rst = 1'b0;
      tick();
`ifdef DCACHE_PERF_CNT_EN
      checkOutput("perf_rst_hits", perf_hits, 32'h0);
      checkOutput("perf_rst_misses", perf_misses, 32'h0);
      checkOutput("perf_rst_wbs", perf_wbs, 32'h0);
`endif
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h0000_1040, 32'h0, 6'd31);
      serveMem("s5_remiss", 1'b0, 32'h0000_1040, '0, mkLine(32'hCAFE_F00D));
      waitResp("s5_remiss", 32'hCAFE_F00D, 6'd31, 1'b0);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
